imm_gen_pipe: RTL and testbench

Next-generation immediate generator for the decode stage. Covers every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount, CSR zimm) and is parametrised on XLEN. It sits between fetch and the register-read stage, with valid/ready handshakes on both sides. One registered output stage plus a skid buffer gives full throughput with a registered in_ready. It also reports the decoded format and flags opcodes that carry no immediate.

---
 rtl/imm_gen_pkg.sv | 26 ++
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_decode_comb.sv | 79 +++++++
 rtl/imm_gen_pipe.sv | 123 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format codes for the decode-stage immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input/output handshake bundle of imm_gen_pipe; master is the upstream/downstream side.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  fmt_e             out_fmt;
  logic             out_noimm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_noimm, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_noimm, out_tag
  );
endinterface

// File: rtl/imm_decode_comb.sv
// Pure combinational RV32I/RV64I immediate decoder; builds a 32-bit immediate, then extends to XLEN.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            noimm_o
);
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] raw;
  logic        sext;

  always_comb begin
    opcode = instr_i[6:0];
    funct3 = instr_i[14:12];
    fmt_o  = FMT_NONE;
    raw    = '0;
    sext   = 1'b1;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_o = FMT_SH;
          sext  = 1'b0;
          raw   = (XLEN == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
        end else begin
          fmt_o = FMT_I;
          raw   = {{20{instr_i[31]}}, instr_i[31:20]};
        end
      end
      OP_IMM32: begin
        // Word ops only exist on RV64; on RV32 the opcode decodes as no-immediate.
        if (XLEN == 64) begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            fmt_o = FMT_SH;
            sext  = 1'b0;
            raw   = {27'b0, instr_i[24:20]};
          end else begin
            fmt_o = FMT_I;
            raw   = {{20{instr_i[31]}}, instr_i[31:20]};
          end
        end
      end
      LOAD, JALR: begin
        fmt_o = FMT_I;
        raw   = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      STORE: begin
        fmt_o = FMT_S;
        raw   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      BRANCH: begin
        fmt_o = FMT_B;
        raw   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        fmt_o = FMT_U;
        raw   = {instr_i[31:12], 12'b0};
      end
      JAL: begin
        fmt_o = FMT_J;
        raw   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      SYSTEM: begin
        if (funct3[2]) begin
          fmt_o = FMT_Z;
          sext  = 1'b0;
          raw   = {27'b0, instr_i[19:15]};
        end
      end
      default: ;
    endcase
    noimm_o = (fmt_o == FMT_NONE);
    imm_o   = sext ? XLEN'($signed(raw)) : XLEN'(raw);
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode into a main output register plus skid.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);
  // Encoding chosen so out_valid and in_ready are direct state-flop bits.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull  = 2'b01,
    StSkid  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             in_hs, out_hs;
  logic             load_main, load_skid, move_skid;

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_noimm;

  logic [XLEN-1:0]  imm_q, skid_imm_q;
  fmt_e             fmt_q, skid_fmt_q;
  logic             noimm_q, skid_noimm_q;
  logic [TAG_W-1:0] tag_q, skid_tag_q;

  imm_decode_comb #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i (bus.in_instr),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt),
    .noimm_o (dec_noimm)
  );

  assign bus.in_ready  = ~state_q[1];
  assign bus.out_valid = state_q[0];
  assign bus.out_imm   = imm_q;
  assign bus.out_fmt   = fmt_q;
  assign bus.out_noimm = noimm_q;
  assign bus.out_tag   = tag_q;

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      StEmpty: begin
        if (in_hs) begin
          load_main = 1'b1;
          state_d   = StFull;
        end
      end
      StFull: begin
        if (in_hs && out_hs) begin
          load_main = 1'b1;
        end else if (in_hs) begin
          load_skid = 1'b1;
          state_d   = StSkid;
        end else if (out_hs) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_hs) begin
          move_skid = 1'b1;
          state_d   = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over any same-cycle transfer; the accepted word is dropped.
    if (flush) begin
      state_d   = StEmpty;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      imm_q        <= '0;
      fmt_q        <= FMT_NONE;
      noimm_q      <= 1'b0;
      tag_q        <= '0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_noimm_q <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        imm_q   <= dec_imm;
        fmt_q   <= dec_fmt;
        noimm_q <= dec_noimm;
        tag_q   <= bus.in_tag;
      end else if (move_skid) begin
        imm_q   <= skid_imm_q;
        fmt_q   <= skid_fmt_q;
        noimm_q <= skid_noimm_q;
        tag_q   <= skid_tag_q;
      end
      if (load_skid) begin
        skid_imm_q   <= dec_imm;
        skid_fmt_q   <= dec_fmt;
        skid_noimm_q <= dec_noimm;
        skid_tag_q   <= bus.in_tag;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, decode, stall, flush, reset.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush32, flush64;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush32),
    .bus   (b32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush64),
    .bus   (b64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t32_instr [8];
  logic [63:0] t32_imm   [8];
  fmt_e        t32_fmt   [8];
  logic        t32_noimm [8];
  logic [31:0] t64_instr [5];
  logic [63:0] t64_imm   [5];
  fmt_e        t64_fmt   [5];
  logic        t64_noimm [5];

  int          sent, got;
  logic        stalled;
  logic [31:0] held_tag;
  logic [63:0] held_imm;

  initial begin
    t32_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F,
                  32'h123450B7, 32'h03F09093, 32'h3401D073, 32'h0010809B};
    t32_imm   = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'h00000800,
                  64'h12345000, 64'h0000001F, 64'h00000003, 64'h0};
    t32_fmt   = '{FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_SH, FMT_Z, FMT_NONE};
    t32_noimm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t64_instr = '{32'h800000B7, 32'h03F09093, 32'h002081B3, 32'h0010809B, 32'hFFF00093};
    t64_imm   = '{64'hFFFFFFFF80000000, 64'd63, 64'd0, 64'd1, 64'hFFFFFFFFFFFFFFFF};
    t64_fmt   = '{FMT_U, FMT_SH, FMT_NONE, FMT_I, FMT_I};
    t64_noimm = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; flush32 = 1'b0; flush64 = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_out_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_out_fmt", 64'(b32.out_fmt), 64'(FMT_NONE));
    chk("rst_out_noimm", 64'(b32.out_noimm), 64'd0);
    chk("rst_out_tag", 64'(b32.out_tag), 64'd0);
    chk("rst64_out_valid", 64'(b64.out_valid), 64'd0);
    rst = 1'b0;

    // XLEN=32 back-to-back stream, one output per cycle, one cycle after input
    for (int i = 0; i < 8; i++) begin
      b32.in_valid = 1'b1;
      b32.in_instr = t32_instr[i];
      b32.in_tag   = 32'(100 + i);
      chk("s32_in_ready", 64'(b32.in_ready), 64'd1);
      tick();
      chk("s32_out_valid", 64'(b32.out_valid), 64'd1);
      chk("s32_out_imm", 64'(b32.out_imm), t32_imm[i]);
      chk("s32_out_fmt", 64'(b32.out_fmt), 64'(t32_fmt[i]));
      chk("s32_out_noimm", 64'(b32.out_noimm), 64'(t32_noimm[i]));
      chk("s32_out_tag", 64'(b32.out_tag), 64'(100 + i));
    end
    b32.in_valid = 1'b0;
    tick();
    chk("s32_drained", 64'(b32.out_valid), 64'd0);

    // XLEN=64 stream
    for (int i = 0; i < 5; i++) begin
      b64.in_valid = 1'b1;
      b64.in_instr = t64_instr[i];
      b64.in_tag   = 32'(150 + i);
      tick();
      chk("s64_out_valid", 64'(b64.out_valid), 64'd1);
      chk("s64_out_imm", b64.out_imm, t64_imm[i]);
      chk("s64_out_fmt", 64'(b64.out_fmt), 64'(t64_fmt[i]));
      chk("s64_out_noimm", 64'(b64.out_noimm), 64'(t64_noimm[i]));
      chk("s64_out_tag", 64'(b64.out_tag), 64'(150 + i));
    end
    b64.in_valid = 1'b0;
    tick();
    chk("s64_drained", 64'(b64.out_valid), 64'd0);

    // Backpressure: 4 instructions, out_ready low for cycles 2..4
    sent = 0; got = 0; stalled = 1'b0; held_tag = '0; held_imm = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      b32.out_ready = !(cyc >= 2 && cyc <= 4);
      b32.in_valid  = (sent < 4);
      b32.in_instr  = t32_instr[sent % 8];
      b32.in_tag    = 32'(200 + sent);
      if (cyc == 3) chk("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
      if (cyc == 6) chk("bp_in_ready_back", 64'(b32.in_ready), 64'd1);
      if (stalled) begin
        chk("bp_hold_valid", 64'(b32.out_valid), 64'd1);
        chk("bp_hold_tag", 64'(b32.out_tag), 64'(held_tag));
        chk("bp_hold_imm", 64'(b32.out_imm), held_imm);
      end
      if (b32.out_valid && b32.out_ready) begin
        chk("bp_order_tag", 64'(b32.out_tag), 64'(200 + got));
        chk("bp_order_imm", 64'(b32.out_imm), t32_imm[got % 8]);
        got++;
      end
      stalled  = b32.out_valid && !b32.out_ready;
      held_tag = b32.out_tag;
      held_imm = 64'(b32.out_imm);
      if (b32.in_valid && b32.in_ready) sent++;
      tick();
    end
    chk("bp_count_out", 64'(got), 64'd4);
    chk("bp_idle", 64'(b32.out_valid), 64'd0);

    // Flush with main and skid occupied
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1; b32.in_instr = t32_instr[0]; b32.in_tag = 32'd300;
    tick();
    b32.in_instr = t32_instr[1]; b32.in_tag = 32'd301;
    tick();
    chk("fl_skid_in_ready", 64'(b32.in_ready), 64'd0);
    flush32 = 1'b1;
    b32.in_instr = t32_instr[2]; b32.in_tag = 32'd302;
    tick();
    flush32 = 1'b0;
    b32.in_valid = 1'b0;
    chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_in_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 64'(b32.out_valid), 64'd0);

    // Flush in FULL beats a same-cycle input handshake
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1; b32.in_instr = t32_instr[3]; b32.in_tag = 32'd310;
    tick();
    flush32 = 1'b1;
    b32.in_instr = t32_instr[4]; b32.in_tag = 32'd311;
    tick();
    flush32 = 1'b0;
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    chk("fl2_out_valid", 64'(b32.out_valid), 64'd0);
    tick();
    chk("fl2_dropped", 64'(b32.out_valid), 64'd0);
    b32.in_valid = 1'b1; b32.in_instr = t32_instr[3]; b32.in_tag = 32'd320;
    tick();
    b32.in_valid = 1'b0;
    chk("fl2_resume_tag", 64'(b32.out_tag), 64'd320);
    chk("fl2_resume_imm", 64'(b32.out_imm), 64'h00000800);

    // Reset mid-stream with skid occupied
    b32.out_ready = 1'b0;
    b32.in_valid  = 1'b1; b32.in_instr = t32_instr[1]; b32.in_tag = 32'd400;
    tick();
    b32.in_instr = t32_instr[2]; b32.in_tag = 32'd401;
    tick();
    rst = 1'b1;
    b32.in_valid = 1'b0;
    tick();
    chk("mrst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("mrst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("mrst_out_imm", 64'(b32.out_imm), 64'd0);
    chk("mrst_out_fmt", 64'(b32.out_fmt), 64'(FMT_NONE));
    chk("mrst_out_noimm", 64'(b32.out_noimm), 64'd0);
    chk("mrst_out_tag", 64'(b32.out_tag), 64'd0);
    rst = 1'b0;
    b32.out_ready = 1'b1;
    b32.in_valid  = 1'b1; b32.in_instr = t32_instr[0]; b32.in_tag = 32'd402;
    tick();
    b32.in_valid = 1'b0;
    chk("mrst_resume_valid", 64'(b32.out_valid), 64'd1);
    chk("mrst_resume_tag", 64'(b32.out_tag), 64'd402);
    chk("mrst_resume_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
    tick();
    chk("mrst_no_leftover", 64'(b32.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
